// File: rtl/rv_dmem.sv
`default_nettype none
// ============================================================================
//  Module      : rv_dmem
//  Description : Synchronous RV32I data memory. Byte-masked read-modify-write
//                stores, 1-cycle registered loads, zero-fill of the array
//                after every reset, and sticky illegal-mask / range flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv_dmem #(
    parameter int MEM_DEPTH = 64
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_data_out,
    input  logic [3:0]  dm_wr_mask,
    input  logic        dm_wr_req,
    output logic [31:0] dm_data_in,
    output logic        dm_ready,
    output logic        err_mask,
    output logic        err_range
);

    localparam int c_AW = $clog2(MEM_DEPTH);

    localparam logic       c_ST_CLEAR = 1'b0;
    localparam logic       c_ST_RUN   = 1'b1;
    localparam logic [c_AW-1:0] c_LAST_IDX = c_AW'(MEM_DEPTH - 1);

    logic              r_state;
    logic [c_AW-1:0]   r_clr_idx;
    logic [31:0]       r_mem [MEM_DEPTH];

    logic [c_AW-1:0]   w_idx;
    logic              w_in_range;
    logic              w_mask_legal;
    logic              w_mask_zero;
    logic [31:0]       w_merged;
    logic              w_unused;

    assign w_idx       = dm_addr[c_AW+1:2];
    assign w_mask_zero = (dm_wr_mask == 4'b0000);
    // Byte offset within the word never matters; aligned data arrives from the core.
    assign w_unused    = ^dm_addr[1:0];

    // Address is in range when every bit above the word index is zero.
    generate
        if (c_AW + 2 < 32) begin : g_range_chk
            assign w_in_range = (dm_addr[31:c_AW+2] == '0);
        end else begin : g_range_full
            assign w_in_range = 1'b1;
        end
    endgenerate

    // Only byte, aligned halfword and full-word masks are legal (zero is a no-op).
    always_comb begin
        w_mask_legal = 1'b0;
        case (dm_wr_mask)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: w_mask_legal = 1'b1;
            default:                   w_mask_legal = 1'b0;
        endcase
    end

    // Per-lane merge: enabled lanes take store data, others keep the old byte.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_merged[8*gi +: 8] = dm_wr_mask[gi] ? dm_data_out[8*gi +: 8]
                                                        : r_mem[w_idx][8*gi +: 8];
        end
    endgenerate

    // Clear/run sequencer, memory writes, registered load data and sticky errors.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= c_ST_CLEAR;
            r_clr_idx  <= '0;
            dm_data_in <= '0;
            dm_ready   <= 1'b0;
            err_mask   <= 1'b0;
            err_range  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_CLEAR: begin
                    r_mem[r_clr_idx] <= '0;
                    r_clr_idx        <= r_clr_idx + 1'b1;
                    dm_data_in       <= '0;
                    if (r_clr_idx == c_LAST_IDX) begin
                        r_state  <= c_ST_RUN;
                        dm_ready <= 1'b1;
                    end
                end
                default: begin
                    if (!w_in_range) begin
                        err_range <= 1'b1;
                    end
                    if (dm_wr_req) begin
                        dm_data_in <= '0;
                        if (!w_mask_legal && !w_mask_zero) begin
                            err_mask <= 1'b1;
                        end
                        if (w_in_range && w_mask_legal) begin
                            r_mem[w_idx] <= w_merged;
                        end
                    end else begin
                        dm_data_in <= w_in_range ? r_mem[w_idx] : 32'd0;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv_dmem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv_dmem
//  Description : Randomised and directed bench for rv_dmem with a word-array
//                reference model of memory contents, clear timing and errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_dmem;

    localparam int DEPTH = 64;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_data_out = '0;
    logic [3:0]  dm_wr_mask = '0;
    logic        dm_wr_req = 1'b0;
    logic [31:0] dm_data_in;
    logic        dm_ready;
    logic        err_mask;
    logic        err_range;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] m_mem [DEPTH];
    int          m_clear_left = DEPTH;
    logic        m_ready = 1'b0;
    logic [31:0] m_data = '0;
    logic        m_err_mask = 1'b0;
    logic        m_err_range = 1'b0;

    rv_dmem #(.MEM_DEPTH(DEPTH)) u_dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .dm_addr     (dm_addr),
        .dm_data_out (dm_data_out),
        .dm_wr_mask  (dm_wr_mask),
        .dm_wr_req   (dm_wr_req),
        .dm_data_in  (dm_data_in),
        .dm_ready    (dm_ready),
        .err_mask    (err_mask),
        .err_range   (err_range)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit legal_mask(input logic [3:0] m);
        return (m == 4'd1) || (m == 4'd2) || (m == 4'd4) || (m == 4'd8) ||
               (m == 4'd3) || (m == 4'd12) || (m == 4'd15);
    endfunction

    // Model of one clock edge, expressed directly in terms of the access rules.
    task automatic model_edge(input logic rst, input logic wr, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] mask);
        bit in_range;
        int idx;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            m_clear_left = DEPTH;
            m_ready      = 1'b0;
            m_data       = '0;
            m_err_mask   = 1'b0;
            m_err_range  = 1'b0;
        end else if (m_clear_left > 0) begin
            m_clear_left--;
            if (m_clear_left == 0) m_ready = 1'b1;
            m_data = '0;
        end else begin
            in_range = (addr < 32'(4 * DEPTH));
            idx      = int'(addr / 4) % DEPTH;
            if (!in_range) m_err_range = 1'b1;
            if (wr) begin
                m_data = '0;
                if (mask != 4'd0 && !legal_mask(mask)) m_err_mask = 1'b1;
                if (in_range && legal_mask(mask)) begin
                    for (int b = 0; b < 4; b++)
                        if (mask[b]) m_mem[idx][8*b +: 8] = data[8*b +: 8];
                end
            end else begin
                m_data = in_range ? m_mem[idx] : 32'd0;
            end
        end
    endtask

    task automatic step(input logic rst, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] mask);
        rst_in      = rst;
        dm_wr_req   = wr;
        dm_addr     = addr;
        dm_data_out = data;
        dm_wr_mask  = mask;
        @(posedge clk_in);
        model_edge(rst, wr, addr, data, mask);
        #1;
        chk("data_in",   dm_data_in,         m_data);
        chk("ready",     {31'd0, dm_ready},  {31'd0, m_ready});
        chk("err_mask",  {31'd0, err_mask},  {31'd0, m_err_mask});
        chk("err_range", {31'd0, err_range}, {31'd0, m_err_range});
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    task automatic load(input logic [31:0] addr);
        step(1'b0, 1'b0, addr, 32'd0, 4'd0);
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
        step(1'b0, 1'b1, addr, data, mask);
    endtask

    // Idle until dm_ready, returning the number of post-reset edges it took.
    task automatic wait_ready(input string tag);
        int n = 0;
        while (n < 200) begin
            idle();
            n++;
            if (dm_ready) break;
        end
        chk(tag, 32'(n), 32'(DEPTH));
    endtask

    initial begin
        logic [3:0]  masks [9];
        logic [31:0] a;
        masks = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd12, 4'd15, 4'd0, 4'd5};

        // 1. Reset and clear
        step(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
        step(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
        wait_ready("clear_len");
        load(32'h00); load(32'd31 * 4); load(32'd63 * 4);
        chk("word63_zero", dm_data_in, 32'd0);

        // 2. Full and partial stores
        store(32'h10, 32'hDEADBEEF, 4'b1111);
        store(32'h10, 32'h000000AA, 4'b0001);
        load(32'h10);
        chk("rmw_byte", dm_data_in, 32'hDEADBEAA);
        store(32'h10, 32'h12340000, 4'b1100);
        load(32'h10);
        chk("rmw_half", dm_data_in, 32'h1234BEAA);
        store(32'h10, 32'hFFFFFFFF, 4'b0000);
        load(32'h10);
        chk("mask_zero", dm_data_in, 32'h1234BEAA);

        // 3. Back-to-back store/load of word 5
        for (int k = 0; k < 8; k++) begin
            store(32'd5 * 4, 32'h100 + 32'(k), 4'b1111);
            chk("b2b_store_zero", dm_data_in, 32'd0);
            load(32'd5 * 4);
            chk("b2b_load", dm_data_in, 32'h100 + 32'(k));
        end

        // 4. Illegal mask and range errors
        store(32'h04, 32'h55555555, 4'b0000);
        store(32'h04, 32'hCAFEF00D, 4'b1111);
        store(32'h04, 32'h11111111, 4'b0101);
        chk("err_mask_set", {31'd0, err_mask}, 32'd1);
        load(32'h04);
        chk("illegal_drop", dm_data_in, 32'hCAFEF00D);
        load(32'h100);
        chk("range_zero", dm_data_in, 32'd0);
        chk("err_range_set", {31'd0, err_range}, 32'd1);
        for (int k = 0; k < 4; k++) load(32'h20);
        chk("sticky_mask", {31'd0, err_mask}, 32'd1);

        // 5. Reset mid-operation, then again at clear index 20
        for (int k = 0; k < 4; k++) store(32'(4 * k), 32'hA5A50000 + 32'(k + 1), 4'b1111);
        step(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
        for (int k = 0; k < 20; k++) idle();
        step(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
        wait_ready("restart_len");
        for (int k = 0; k < 4; k++) begin
            load(32'(4 * k));
            chk("cleared_word", dm_data_in, 32'd0);
        end

        // 6. Access during clear is ignored
        step(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
        for (int k = 0; k < 10; k++) store(32'h08, 32'hFFFFFFFF, 4'b1111);
        store(32'h08, 32'hFFFFFFFF, 4'b0101);
        store(32'h400, 32'hFFFFFFFF, 4'b1111);
        for (int k = 0; k < DEPTH - 12; k++) idle();
        chk("ready_after_clear", {31'd0, dm_ready}, 32'd1);
        load(32'h08);
        chk("clear_store_dropped", dm_data_in, 32'd0);
        chk("clear_no_err", {30'd0, err_mask, err_range}, 32'd0);

        // Randomised traffic with occasional resets
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 15) == 0)
                a = $urandom;
            else
                a = {24'd0, 6'($urandom_range(0, 15)), 2'($urandom)};
            if ($urandom_range(0, 499) == 0)
                step(1'b1, 1'b0, a, 32'd0, 4'd0);
            else if ($urandom_range(0, 1) == 1)
                store(a, $urandom,
                      ($urandom_range(0, 29) == 0) ? 4'($urandom) : masks[$urandom_range(0, 7)]);
            else
                step(1'b0, 1'b0, a, 32'd0, 4'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rv_dmem.md
# rv_dmem

Synchronous data memory for the RV32I core. Sits directly downstream of the core's data port (`Riscv_Top`) and consumes its address, store data, byte mask and write request. It returns registered load data one cycle later. After every reset it zero-initialises its array with a sequential clear state machine. It also flags illegal store masks and out-of-range addresses with sticky error bits.

## Interface

**Parameters**
- `MEM_DEPTH`, 64: number of 32-bit words. Must be a power of 2 and ≥ 2. `AW = $clog2(MEM_DEPTH)`.

**Ports**
- `clk_in` in 1: single clock; all state updates on the rising edge.
- `rst_in` in 1: reset, synchronous, active-high.
- `dm_addr` in 32: byte address from the core. Word index = `dm_addr[AW+1:2]`. `dm_addr[1:0]` is ignored.
- `dm_data_out` in 32: store data from the core, already lane-aligned.
- `dm_wr_mask` in 4: byte-lane enables. Bit n covers bits [8n+7:8n].
- `dm_wr_req` in 1: 1 = store this cycle, 0 = load.
- `dm_data_in` out 32: registered load data returned to the core.
- `dm_ready` out 1: 1 when the clear sequence is done and accesses are honoured.
- `err_mask` out 1: sticky; set by a store with an illegal mask.
- `err_range` out 1: sticky; set by any access with `dm_addr[31:AW+2] != 0`.

## Operation

**State machine**
- States are CLEAR and RUN.
- `rst_in` forces CLEAR, `clr_idx <= 0`, `dm_data_in <= 0`, `dm_ready <= 0`, `err_mask <= 0`, `err_range <= 0`.
- Reset has priority over everything, including a reset that arrives mid-CLEAR: the clear restarts at index 0.
- In CLEAR, each cycle writes `mem[clr_idx] <= 0` and increments `clr_idx`.
- When `clr_idx == MEM_DEPTH-1` is written, go to RUN and set `dm_ready <= 1`.
- CLEAR lasts exactly `MEM_DEPTH` cycles.
- Core accesses during CLEAR are ignored: no write, no error update, `dm_data_in` held at 0.

**RUN, store (`dm_wr_req=1`)**
- Legal masks: 0001, 0010, 0100, 1000, 0011, 1100, 1111.
- A legal mask with an in-range address does a read-modify-write per lane. Enabled lanes take `dm_data_out`; disabled lanes keep their old memory bytes. Unmasked bytes are never zeroed.
- Mask 0000 is a no-op and not an error.
- Any other mask sets `err_mask` and the store is dropped.
- An out-of-range address sets `err_range` and the store is dropped.
- In a store cycle, `dm_data_in <= 0`.

**RUN, load (`dm_wr_req=0`)**
- `dm_data_in <= mem[word index]` when the address is in range.
- When out of range: `dm_data_in <= 0` and `err_range` is set. `dm_wr_mask` is ignored on loads.

**Errors**
- Error bits clear only on reset.
- Both error bits may set in the same cycle, e.g. an illegal mask to an out-of-range address.

## Timing

- Load latency is 1 cycle. An address presented in cycle N gives data on `dm_data_in` after edge N+1, valid throughout cycle N+1.
- A store commits at the edge ending its cycle. A load of the same word in the next cycle returns the new data; no forwarding path is needed.
- There are no simultaneous read and write; `dm_wr_req` selects one per cycle.
- Back-to-back accesses every cycle with no bubbles; the core is never stalled once `dm_ready=1`.
- `dm_ready` rises on the edge ending clear cycle `MEM_DEPTH-1`, i.e. `MEM_DEPTH` edges after the reset deassert edge. The first honoured access is in the cycle where `dm_ready` reads 1.
- Error bits assert at the edge ending the offending cycle.

## Test plan

1. **Reset and clear.** Assert `rst_in` 2 cycles, release, idle.
   - During clear: `dm_ready=0` for exactly 64 cycles, then 1; `dm_data_in=0` throughout.
   - Loads of words 0, 31 and 63 return 0.
2. **Full and partial stores.**
   - Store 0xDEADBEEF to 0x10 with mask 1111, then mask 0001 with data 0x000000AA; a load of 0x10 returns 0xDEADBEAA.
   - Mask 1100 with 0x12340000 then gives 0x1234BEAA.
   - Mask 0000 leaves the word unchanged.
3. **Back-to-back and latency.**
   - Alternate a store to word 5 and a load of word 5 every cycle, with incrementing data.
   - Each load returns the preceding store's value one cycle later; `dm_data_in=0` in store cycles.
4. **Illegal mask and range errors.**
   - A store with mask 0101 to 0x04 sets `err_mask` and word 1 is unchanged.
   - A load of 0x100 (word 64, `MEM_DEPTH=64`) returns 0 and sets `err_range`.
   - Both bits stay set until reset.
5. **Reset mid-operation.**
   - Write nonzero data to words 0–3, then assert `rst_in` at clear index 20 of a second clear.
   - The clear restarts and `dm_ready` is 0 for 64 cycles after release.
   - All words read 0 and the error bits are 0.
6. **Access during clear.** Issue a store of 0xFFFFFFFF to word 2 during CLEAR; after `dm_ready`, word 2 reads 0 and no error bit is set.
